// File: rtl/fft_pkg.sv
// Shared constants, FSM state types and the bit-reversal helper for the
// 16-point IFFT output reorder path.
package fft_pkg;

    localparam int unsigned FFT_LOG2N  = 4;
    localparam int unsigned FFT_N      = 1 << FFT_LOG2N;
    localparam int unsigned FFT_DATA_W = 24;

    typedef enum logic {
        WR_WAIT_SOF = 1'b0,
        WR_FILL     = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
        logic [FFT_LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
            r[i] = k[FFT_LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port buffer RAM: synchronous write, registered read with
// enable so the read word holds between reads.
module fft_reorder_ram #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Only the output register is reset; the array contents are left as-is.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: writes bit-reversed IFFT output into one bank
// while the other bank is drained in natural index order.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = FFT_DATA_W,
    parameter int unsigned LOG2N  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              reset_p,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_sof,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_err
);

    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    wr_state_t        wr_state_d, wr_state_q;
    rd_state_t        rd_state_d, rd_state_q;
    logic [LOG2N-1:0] wr_cnt_d, wr_cnt_q;
    logic [LOG2N-1:0] rd_cnt_d, rd_cnt_q;
    logic             wr_bank_d, wr_bank_q;
    logic             rd_bank_d, rd_bank_q;
    logic [1:0]       full_d, full_q;
    logic             frame_err_d, frame_err_q;
    logic             out_valid_d, out_valid_q;
    logic             out_sof_d, out_sof_q;

    logic             ram_wr_en;
    logic [LOG2N:0]   ram_wr_addr;
    logic             ram_rd_en;
    logic [LOG2N:0]   ram_rd_addr;

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        full_d      = full_q;
        frame_err_d = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_addr = {wr_bank_q, bitrev(wr_cnt_q)};

        case (wr_state_q)
            WR_WAIT_SOF: begin
                if (in_valid && in_sof) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_addr = {wr_bank_q, {LOG2N{1'b0}}};
                    wr_cnt_d    = {{(LOG2N-1){1'b0}}, 1'b1};
                    wr_state_d  = WR_FILL;
                end
            end
            WR_FILL: begin
                if (in_valid) begin
                    ram_wr_en = 1'b1;
                    if (in_sof) begin
                        // Early SOF: abandon the partial frame and restart this bank.
                        frame_err_d = 1'b1;
                        ram_wr_addr = {wr_bank_q, {LOG2N{1'b0}}};
                        wr_cnt_d    = {{(LOG2N-1){1'b0}}, 1'b1};
                    end else if (wr_cnt_q == LAST_IDX) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d         = ~wr_bank_q;
                        wr_cnt_d          = '0;
                        wr_state_d        = WR_WAIT_SOF;
                    end else begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            default: wr_state_d = WR_WAIT_SOF;
        endcase
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        rd_cnt_d    = rd_cnt_q;
        rd_bank_d   = rd_bank_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = {rd_bank_q, rd_cnt_q};
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;

        case (rd_state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                ram_rd_en   = 1'b1;
                out_valid_d = 1'b1;
                out_sof_d   = (rd_cnt_q == '0);
                rd_cnt_d    = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_bank_d = ~rd_bank_q;
                    if (!full_q[~rd_bank_q]) begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // The write side only ever sets the fill bank; the read side only clears the drain bank.
    logic [1:0] full_clr;
    always_comb begin
        full_clr = 2'b00;
        if (rd_state_q == RD_DRAIN && rd_cnt_q == LAST_IDX) begin
            full_clr[rd_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            wr_state_q  <= WR_WAIT_SOF;
            rd_state_q  <= RD_IDLE;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            frame_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d & ~full_clr;
            frame_err_q <= frame_err_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    fft_reorder_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2N + 1)
    ) u_ram (
        .clk     (clk),
        .reset_p (reset_p),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (in_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (out_data)
    );

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign frame_err = frame_err_q;

endmodule
